dbus_resp_mux: RTL

Data-bus response path for the 6-stage core: the return side of the chip-select address decoder. It accepts one CPU data-bus request at a time and latches which slave the decoder selected (DMEM, TBMAN, GPIO, TIMER, UART). It then waits for that slave's acknowledge, steers the slave's read data back to the core as a single-cycle response, and terminates unmapped or hung accesses with an error response.

---
 rtl/dbus_pkg.sv | 34 +++
 rtl/dbus_timeout_ctr.sv | 37 +++
 rtl/dbus_resp_mux.sv | 131 +++++++++++++
 3 files changed

// File: rtl/dbus_pkg.sv
// Shared definitions for the data-bus response path: slave indices, FSM states,
// the default error data word and the select-priority helper.
package dbus_pkg;

  localparam int unsigned NUM_SLAVES = 5;

  localparam int unsigned SLV_DMEM  = 0;
  localparam int unsigned SLV_TBMAN = 1;
  localparam int unsigned SLV_GPIO  = 2;
  localparam int unsigned SLV_TIMER = 3;
  localparam int unsigned SLV_UART  = 4;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  // One-hot of the lowest-index active (low) chip select; DMEM wins on overlap.
  function automatic logic [NUM_SLAVES-1:0] lowest_sel(input logic [NUM_SLAVES-1:0] cs_n);
    logic found;
    lowest_sel = '0;
    found      = 1'b0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (!cs_n[i] && !found) begin
        lowest_sel[i] = 1'b1;
        found         = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/dbus_timeout_ctr.sv
// 8-bit wait-cycle counter; expire_o flags the last allowed WAIT cycle
// (count == TIMEOUT_CYCLES-1).
module dbus_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [7:0] EXPIRE_AT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == EXPIRE_AT);

endmodule

// File: rtl/dbus_resp_mux.sv
// Data-bus response path: latches the decoded slave select, waits for that
// slave's ack (or a timeout) and returns a one-cycle response to the core.
module dbus_resp_mux
  import dbus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [NUM_SLAVES-1:0] cs_n,
  output logic                  req_ready,
  input  logic [NUM_SLAVES-1:0] slv_ack,
  input  logic [31:0]           dmem_rdata,
  input  logic [31:0]           tbman_rdata,
  input  logic [31:0]           gpio_rdata,
  input  logic [31:0]           timer_rdata,
  input  logic [31:0]           uart_rdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err
);

  state_e                  state_q, state_d;
  logic [NUM_SLAVES-1:0]   sel_q, sel_d;
  logic                    we_q, we_d;
  logic [31:0]             data_q, data_d;
  logic                    err_q, err_d;
  logic                    ctr_clr, ctr_en, ctr_expire;

  logic [NUM_SLAVES-1:0][31:0] rdata_arr;
  logic [31:0]                 rdata_sel;

  assign rdata_arr[SLV_DMEM]  = dmem_rdata;
  assign rdata_arr[SLV_TBMAN] = tbman_rdata;
  assign rdata_arr[SLV_GPIO]  = gpio_rdata;
  assign rdata_arr[SLV_TIMER] = timer_rdata;
  assign rdata_arr[SLV_UART]  = uart_rdata;

  // AND-OR steering on the latched one-hot select.
  always_comb begin
    rdata_sel = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      rdata_sel = rdata_sel | (rdata_arr[i] & {32{sel_q[i]}});
    end
  end

  dbus_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (ctr_clr),
    .en_i    (ctr_en),
    .expire_o(ctr_expire)
  );

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    we_d      = we_q;
    data_d    = data_q;
    err_d     = err_q;
    ctr_clr   = 1'b0;
    ctr_en    = 1'b0;
    req_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          ctr_clr = 1'b1;
          if (&cs_n) begin
            sel_d   = '0;
            err_d   = 1'b1;
            data_d  = ERR_DATA;
            state_d = RESP;
          end else begin
            sel_d   = lowest_sel(cs_n);
            we_d    = req_we;
            err_d   = 1'b0;
            data_d  = '0;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // An ack in the expiry cycle still completes normally.
        if (|(slv_ack & sel_q)) begin
          data_d  = we_q ? '0 : rdata_sel;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (ctr_expire) begin
          data_d  = ERR_DATA;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          ctr_en = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      we_q    <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_valid ? data_q : '0;
  assign resp_err   = resp_valid & err_q;

endmodule
